// File: rtl/regfile_wb_scheduler_if.sv
// regfile_wb_scheduler_if: issue, write-back and register-file signal bundle for regfile_wb_scheduler
interface regfile_wb_scheduler_if;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_uses_rs1, issue_uses_rs2, issue_writes_rd, issue_long;
  logic        issue_stall;
  logic        ex_wb_valid, ex_wb_ready;
  logic [4:0]  ex_wb_rd;
  logic [31:0] ex_wb_data;
  logic        mem_wb_valid, mem_wb_ready;
  logic [4:0]  mem_wb_rd;
  logic [31:0] mem_wb_data;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic [31:0] busy;
  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_uses_rs1, issue_uses_rs2,
           issue_writes_rd, issue_long, ex_wb_valid, ex_wb_rd, ex_wb_data,
           mem_wb_valid, mem_wb_rd, mem_wb_data,
    input  issue_stall, ex_wb_ready, mem_wb_ready, rf_we, rf_a3, rf_wd3, busy
  );
  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_uses_rs1, issue_uses_rs2,
           issue_writes_rd, issue_long, ex_wb_valid, ex_wb_rd, ex_wb_data,
           mem_wb_valid, mem_wb_rd, mem_wb_data,
    output issue_stall, ex_wb_ready, mem_wb_ready, rf_we, rf_a3, rf_wd3, busy
  );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: shares the register-file write port between execute and memory results and stalls issue on hazards with outstanding loads; REGFILE_WB_STARVE_GUARD_EN enables the memory starvation guard
module regfile_wb_scheduler #(
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_PENDING  = 2
) (
  input logic clk,
  input logic rst,
  regfile_wb_scheduler_if.slave bus
);
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || MAX_PENDING < 1 || MAX_PENDING > 7) begin : g_bad_params
    $error("regfile_wb_scheduler: parameter out of range");
  end
  logic [31:0] busy_q, busy_nxt, clr_mask, set_mask;
  logic [2:0]  pending, pending_nxt;
  logic        rf_we_q, mem_src, starve_fire, ex_acc, mem_acc, long_acc;
  logic [4:0]  rf_a3_q, wb_rd;
  logic [31:0] rf_wd3_q, wb_data;
`ifdef REGFILE_WB_STARVE_GUARD_EN
  logic [3:0] starve;
  assign starve_fire = starve == 4'(STARVE_LIMIT);
  // count cycles a memory result has been refused; any accept or idle cycle restarts it
  always_ff @(posedge clk)
    starve <= rst ? 4'd0 : (bus.mem_wb_valid && !bus.mem_wb_ready) ? starve + 4'd1 : 4'd0;
`else
  assign starve_fire = 1'b0;
`endif
  // hazard check against registered scoreboard, port arbitration and next-state terms
  always_comb begin
    bus.issue_stall = bus.issue_valid && (
      (bus.issue_uses_rs1 && busy_q[bus.issue_rs1]) ||
      (bus.issue_uses_rs2 && busy_q[bus.issue_rs2]) ||
      (bus.issue_writes_rd && busy_q[bus.issue_rd]) ||
      (bus.issue_long && pending == 3'(MAX_PENDING)));
    bus.ex_wb_ready  = !starve_fire;
    bus.mem_wb_ready = !bus.ex_wb_valid || starve_fire;
    ex_acc   = bus.ex_wb_valid && bus.ex_wb_ready;
    mem_acc  = bus.mem_wb_valid && bus.mem_wb_ready;
    long_acc = bus.issue_valid && !bus.issue_stall && bus.issue_long;
    wb_rd    = mem_acc ? bus.mem_wb_rd : bus.ex_wb_rd;
    wb_data  = mem_acc ? bus.mem_wb_data : bus.ex_wb_data;
    clr_mask = (rf_we_q && mem_src) ? 32'd1 << rf_a3_q : 32'd0;
    set_mask = (long_acc && bus.issue_writes_rd) ? 32'd1 << bus.issue_rd : 32'd0;
    busy_nxt = ((busy_q & ~clr_mask) | set_mask) & ~32'd1;
    pending_nxt = long_acc ? (mem_acc ? pending : pending + 3'd1)
                : (mem_acc && pending != 3'd0) ? pending - 3'd1 : pending;
  end
  // register the winning write-back and update the scoreboard
  always_ff @(posedge clk)
    if (rst) begin
      rf_we_q  <= 1'b0;
      rf_a3_q  <= 5'd0;
      rf_wd3_q <= 32'd0;
      mem_src  <= 1'b0;
      busy_q   <= 32'd0;
      pending  <= 3'd0;
    end else begin
      rf_we_q <= (ex_acc || mem_acc) && wb_rd != 5'd0;
      if (ex_acc || mem_acc) begin
        rf_a3_q  <= wb_rd;
        rf_wd3_q <= wb_data;
        mem_src  <= mem_acc;
      end
      busy_q  <= busy_nxt;
      pending <= pending_nxt;
    end
  assign bus.rf_we  = rf_we_q;
  assign bus.rf_a3  = rf_a3_q;
  assign bus.rf_wd3 = rf_wd3_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler: directed and random stimulus checked against a cycle-level scoreboard model
module tb_regfile_wb_scheduler;
  localparam int STARVE_LIMIT = 4;
  localparam int MAX_PENDING  = 2;
`ifdef REGFILE_WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  int n_checks = 0;
  int n_fail = 0;
  bit m_busy [32];
  int m_pend, m_starve, m_clr;
  logic m_we;
  logic [4:0] m_a3;
  logic [31:0] m_wd3;
  always #5 clk = ~clk;
  regfile_wb_scheduler_if bus();
  regfile_wb_scheduler #(.STARVE_LIMIT(STARVE_LIMIT), .MAX_PENDING(MAX_PENDING)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_pend = 0;
    m_starve = 0;
    m_clr = 0;
    m_we = 1'b0;
    m_a3 = 5'd0;
    m_wd3 = 32'd0;
  endtask
  task automatic idle();
    bus.issue_valid = 0; bus.issue_rs1 = 0; bus.issue_rs2 = 0; bus.issue_rd = 0;
    bus.issue_uses_rs1 = 0; bus.issue_uses_rs2 = 0; bus.issue_writes_rd = 0; bus.issue_long = 0;
    bus.ex_wb_valid = 0; bus.ex_wb_rd = 0; bus.ex_wb_data = 0;
    bus.mem_wb_valid = 0; bus.mem_wb_rd = 0; bus.mem_wb_data = 0;
  endtask
  task automatic issue(input logic [4:0] rs1, input bit u1, input logic [4:0] rd, input bit wr, input bit lng);
    bus.issue_valid = 1; bus.issue_rs1 = rs1; bus.issue_uses_rs1 = u1;
    bus.issue_rs2 = 0; bus.issue_uses_rs2 = 0;
    bus.issue_rd = rd; bus.issue_writes_rd = wr; bus.issue_long = lng;
  endtask
  task automatic mem(input logic [4:0] rd, input logic [31:0] d);
    bus.mem_wb_valid = 1; bus.mem_wb_rd = rd; bus.mem_wb_data = d;
  endtask
  task automatic cycle();
    bit fire, e_stall, e_exr, e_memr, ex_acc, mem_acc, iss_acc;
    logic [31:0] pb;
    #1;
    fire = GUARD && m_starve == STARVE_LIMIT;
    e_stall = bus.issue_valid && ((bus.issue_uses_rs1 && m_busy[bus.issue_rs1]) ||
      (bus.issue_uses_rs2 && m_busy[bus.issue_rs2]) || (bus.issue_writes_rd && m_busy[bus.issue_rd]) ||
      (bus.issue_long && m_pend == MAX_PENDING));
    e_exr = !fire;
    e_memr = !bus.ex_wb_valid || fire;
    check("issue_stall", bus.issue_stall, e_stall);
    check("ex_wb_ready", bus.ex_wb_ready, e_exr);
    check("mem_wb_ready", bus.mem_wb_ready, e_memr);
    ex_acc = bus.ex_wb_valid && e_exr;
    mem_acc = bus.mem_wb_valid && e_memr;
    iss_acc = bus.issue_valid && !e_stall;
    if (rst) model_reset();
    else begin
      if (m_clr != 0) m_busy[m_clr] = 1'b0;
      m_clr = mem_acc ? int'(bus.mem_wb_rd) : 0;
      if (iss_acc && bus.issue_long && bus.issue_writes_rd && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
      m_pend = m_pend + int'(iss_acc && bus.issue_long) - int'(mem_acc);
      if (m_pend < 0) m_pend = 0;
      m_starve = (bus.mem_wb_valid && !e_memr) ? m_starve + 1 : 0;
      if (ex_acc || mem_acc) begin
        m_a3 = mem_acc ? bus.mem_wb_rd : bus.ex_wb_rd;
        m_wd3 = mem_acc ? bus.mem_wb_data : bus.ex_wb_data;
        m_we = m_a3 != 0;
      end else m_we = 1'b0;
    end
    @(posedge clk);
    #1;
    foreach (m_busy[i]) pb[i] = m_busy[i];
    check("rf_we", bus.rf_we, m_we);
    check("rf_a3", bus.rf_a3, m_a3);
    check("rf_wd3", bus.rf_wd3, m_wd3);
    check("busy", bus.busy, pb);
  endtask
  initial begin
    idle();
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    cycle();
    rst = 0;
    cycle();
    check("reset_busy", bus.busy, 32'd0);
    check("reset_rf_we", bus.rf_we, 1'b0);
    check("reset_rf_wd3", bus.rf_wd3, 32'd0);
    issue(5'd5, 1, 5'd0, 0, 0);
    #1 check("idle_issue_nostall", bus.issue_stall, 1'b0);
    cycle();
    idle();
    issue(5'd0, 0, 5'd7, 1, 1);
    cycle();
    issue(5'd7, 1, 5'd0, 0, 0);
    cycle();
    check("raw_stall_7", bus.issue_stall, 1'b1);
    cycle();
    mem(5'd7, 32'hDEADBEEF);
    cycle();
    bus.mem_wb_valid = 0;
    check("load_rf_we", bus.rf_we, 1'b1);
    check("load_rf_a3", bus.rf_a3, 5'd7);
    check("load_rf_wd3", bus.rf_wd3, 32'hDEADBEEF);
    check("stall_n1", bus.issue_stall, 1'b1);
    cycle();
    check("busy7_clear", bus.busy[7], 1'b0);
    check("stall_n2", bus.issue_stall, 1'b0);
    idle();
    cycle();
    bus.ex_wb_valid = 1; bus.ex_wb_rd = 5'd3; bus.ex_wb_data = 32'h0000_1111;
    mem(5'd9, 32'h0000_2222);
    for (int i = 0; i < 6; i++) begin
      #1 check("ex_ready_arb", bus.ex_wb_ready, !(GUARD && i == STARVE_LIMIT));
      check("mem_ready_arb", bus.mem_wb_ready, GUARD && i == STARVE_LIMIT);
      cycle();
      if (GUARD && i == STARVE_LIMIT) bus.mem_wb_valid = 0;
    end
    idle();
    cycle();
    issue(5'd0, 0, 5'd10, 1, 1);
    cycle();
    issue(5'd0, 0, 5'd11, 1, 1);
    cycle();
    issue(5'd0, 0, 5'd12, 1, 1);
    #1 check("max_pending_stall", bus.issue_stall, 1'b1);
    cycle();
    idle();
    mem(5'd10, 32'hA);
    cycle();
    issue(5'd0, 0, 5'd12, 1, 1);
    mem(5'd11, 32'hB);
    cycle();
    idle();
    issue(5'd0, 0, 5'd13, 1, 1);
    cycle();
    issue(5'd0, 0, 5'd14, 1, 1);
    #1 check("pending_kept_stall", bus.issue_stall, 1'b1);
    cycle();
    idle();
    mem(5'd12, 32'hC);
    cycle();
    mem(5'd13, 32'hD);
    cycle();
    mem(5'd0, 32'h1234);
    #1 check("rd0_mem_ready", bus.mem_wb_ready, 1'b1);
    cycle();
    check("rd0_no_write", bus.rf_we, 1'b0);
    idle();
    issue(5'd0, 0, 5'd3, 1, 1);
    cycle();
    idle();
    check("busy3_set", bus.busy[3], 1'b1);
    rst = 1;
    cycle();
    rst = 0;
    check("rst_busy", bus.busy, 32'd0);
    check("rst_rf_we", bus.rf_we, 1'b0);
    issue(5'd0, 0, 5'd4, 1, 1);
    cycle();
    issue(5'd0, 0, 5'd5, 1, 1);
    #1 check("rst_pending_clear", bus.issue_stall, 1'b0);
    cycle();
    for (int n = 0; n < 400; n++) begin
      rst = $urandom_range(63) == 0;
      bus.issue_valid = $urandom_range(1);
      bus.issue_rs1 = 5'($urandom_range(7));
      bus.issue_rs2 = 5'($urandom_range(7));
      bus.issue_rd = 5'($urandom_range(7));
      bus.issue_uses_rs1 = $urandom_range(1);
      bus.issue_uses_rs2 = $urandom_range(1);
      bus.issue_writes_rd = $urandom_range(1);
      bus.issue_long = $urandom_range(1);
      bus.ex_wb_valid = $urandom_range(3) != 0;
      bus.ex_wb_rd = 5'($urandom_range(31));
      bus.ex_wb_data = $urandom;
      bus.mem_wb_valid = $urandom_range(1);
      bus.mem_wb_rd = 5'($urandom_range(7));
      bus.mem_wb_data = $urandom;
      cycle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
